// File: rtl/obstacle_scroller.sv
// Obstacle geometry source for Flappy: scrolls the obstacle X edge, draws a
// pseudo-random gap Y edge, counts bird passes, and runs the Start/Lose/Ack session.
module obstacle_scroller #(
    parameter int unsigned X_START   = 640,
    parameter int unsigned SPEED     = 1,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned BIRD_X    = 320,
    parameter int unsigned Y_MIN     = 100,
    parameter int unsigned Y_MAX     = 340,
    parameter int unsigned Y_INIT    = 240,
    parameter logic [9:0]  LFSR_SEED = 10'h2A5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Lose,
    input  logic       Ack,
    output logic [9:0] X_Edge,
    output logic [9:0] Y_Edge,
    output logic       Pass,
    output logic [3:0] Score,
    output logic       Q_Idle,
    output logic       Q_Run,
    output logic       Q_Done
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0] X_START_W = 10'(X_START);
    localparam logic [9:0] SPEED_W   = 10'(SPEED);
    localparam logic [9:0] BIRD_X_W  = 10'(BIRD_X);
    localparam logic [9:0] Y_MIN_W   = 10'(Y_MIN);
    localparam logic [9:0] Y_MAX_W   = 10'(Y_MAX);
    localparam logic [9:0] Y_INIT_W  = 10'(Y_INIT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [3:0]    score_q, score_d;
    logic          pass_q, pass_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    lfsr_q, lfsr_d;
    logic [9:0]    y_sum, y_new;
    logic          tick;

    always_comb begin
        // x^10 + x^7 + 1, shifted every clock regardless of state
        lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        y_sum   = Y_MIN_W + {2'b00, lfsr_q[7:0]};
        y_new   = (y_sum > Y_MAX_W) ? Y_MAX_W : y_sum;
        tick    = (cnt_q == TICK_LAST);

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        pass_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                x_d     = X_START_W;
                y_d     = Y_INIT_W;
                score_d = '0;
                cnt_d   = '0;
                if (Start) begin
                    state_d = S_RUN;
                    y_d     = y_new;
                end
            end
            S_RUN: begin
                // Lose wins over a coincident tick so the collision frame is held
                if (Lose) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + CW'(1);
                    if (tick) begin
                        if (x_q > SPEED_W) begin
                            x_d = x_q - SPEED_W;
                            if ((x_q >= BIRD_X_W) && (x_d < BIRD_X_W)) begin
                                pass_d  = 1'b1;
                                score_d = (score_q == 4'd15) ? score_q : score_q + 4'd1;
                            end
                        end else begin
                            x_d = X_START_W;
                            y_d = y_new;
                        end
                    end
                end
            end
            S_DONE: begin
                if (Ack) begin
                    state_d = S_IDLE;
                    x_d     = X_START_W;
                    y_d     = Y_INIT_W;
                    score_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= X_START_W;
            y_q     <= Y_INIT_W;
            score_q <= '0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            score_q <= score_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign X_Edge = x_q;
    assign Y_Edge = y_q;
    assign Pass   = pass_q;
    assign Score  = score_q;
    assign Q_Idle = (state_q == S_IDLE);
    assign Q_Run  = (state_q == S_RUN);
    assign Q_Done = (state_q == S_DONE);

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed, scoreboard-based bench for obstacle_scroller: default instance for
// scroll/pass/wrap/lose/ack, and a TICK_DIV=4, SPEED=3 instance for pacing and async reset.
module tb_obstacle_scroller;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       Start = 1'b0, Lose = 1'b0, Ack = 1'b0;
    logic [9:0] X_Edge, Y_Edge;
    logic       Pass, Q_Idle, Q_Run, Q_Done;
    logic [3:0] Score;

    logic       rst4 = 1'b1;
    logic       Start4 = 1'b0;
    logic [9:0] X4, Y4;
    logic       Pass4, Q_Idle4, Q_Run4, Q_Done4;
    logic [3:0] Score4;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [9:0]  m_lfsr;

    always #5 Clk = ~Clk;

    obstacle_scroller dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Lose(Lose), .Ack(Ack),
        .X_Edge(X_Edge), .Y_Edge(Y_Edge), .Pass(Pass), .Score(Score),
        .Q_Idle(Q_Idle), .Q_Run(Q_Run), .Q_Done(Q_Done)
    );

    obstacle_scroller #(.TICK_DIV(4), .SPEED(3)) dut4 (
        .Clk(Clk), .reset(rst4), .Start(Start4), .Lose(1'b0), .Ack(1'b0),
        .X_Edge(X4), .Y_Edge(Y4), .Pass(Pass4), .Score(Score4),
        .Q_Idle(Q_Idle4), .Q_Run(Q_Run4), .Q_Done(Q_Done4)
    );

    // Reference LFSR for the default instance: x^10 + x^7 + 1 from seed 0x2A5
    always @(posedge Clk or negedge reset) begin
        if (!reset) m_lfsr <= 10'h2A5;
        else        m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    function automatic logic [9:0] ynew(input logic [9:0] l);
        int s;
        s = 100 + int'(l[7:0]);
        if (s > 340) s = 340;
        return 10'(s);
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_next(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d expected <none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [9:0] xm, ym, old;
        logic       pm;
        int         sm;

        // 1. reset
        #2 reset = 1'b0; rst4 = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        reset = 1'b1; rst4 = 1'b1;
        expect_val("rst_x", 640);    check_next(X_Edge);
        expect_val("rst_y", 240);    check_next(Y_Edge);
        expect_val("rst_score", 0);  check_next(Score);
        expect_val("rst_pass", 0);   check_next(Pass);
        expect_val("rst_idle", 1);   check_next(Q_Idle);
        expect_val("rst_run", 0);    check_next(Q_Run);
        expect_val("rst_done", 0);   check_next(Q_Done);
        for (int i = 0; i < 20; i++) begin
            expect_val("idle_x_hold", 640);
            step();
            check_next(X_Edge);
        end

        // 2. start with default parameters
        ym = ynew(m_lfsr);
        expect_val("start_run", 1);
        expect_val("start_y", ym);
        expect_val("start_y_range", 1);
        expect_val("start_x", 640);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check_next(Q_Run);
        check_next(Y_Edge);
        check_next((Y_Edge >= 10'd100) && (Y_Edge <= 10'd340));
        check_next(X_Edge);

        // 3/4. scroll, pass at 320->319, wrap at 1, 17 laps saturate score, end at X=500
        xm = 640; sm = 0;
        for (int c = 0; c < 640 * 17 + 140; c++) begin
            old = xm;
            if (xm > 1) xm = xm - 1;
            else begin
                xm = 640;
                ym = ynew(m_lfsr);
            end
            pm = (old >= 320) && (xm < 320);
            if (pm && sm < 15) sm++;
            expect_val("run_x", xm);
            expect_val("run_pass", pm);
            expect_val("run_score", sm);
            expect_val("run_y", ym);
            step();
            check_next(X_Edge);
            check_next(Pass);
            check_next(Score);
            check_next(Y_Edge);
        end

        // 5. Lose coincident with a tick at X=500, then Ack
        expect_val("lose_done", 1);
        expect_val("lose_x", 500);
        expect_val("lose_y", ym);
        expect_val("lose_score", 15);
        expect_val("lose_pass", 0);
        Lose = 1'b1;
        step();
        Lose = 1'b0;
        check_next(Q_Done);
        check_next(X_Edge);
        check_next(Y_Edge);
        check_next(Score);
        check_next(Pass);
        for (int i = 0; i < 50; i++) begin
            expect_val("done_x_hold", 500);
            expect_val("done_state", 1);
            Start = (i == 10);
            step();
            check_next(X_Edge);
            check_next(Q_Done);
        end
        Start = 1'b0;
        expect_val("ack_idle", 1);
        expect_val("ack_x", 640);
        expect_val("ack_y", 240);
        expect_val("ack_score", 0);
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        check_next(Q_Idle);
        check_next(X_Edge);
        check_next(Y_Edge);
        check_next(Score);

        // 6. TICK_DIV=4, SPEED=3 pacing, then async reset between edges
        expect_val("div_run", 1);
        expect_val("div_x_entry", 640);
        Start4 = 1'b1;
        step();
        Start4 = 1'b0;
        check_next(Q_Run4);
        check_next(X4);
        for (int n = 1; n <= 12; n++) begin
            expect_val("div_x", 640 - 3 * (n / 4));
            step();
            check_next(X4);
        end
        expect_val("arst_x", 640);
        expect_val("arst_y", 240);
        expect_val("arst_idle", 1);
        expect_val("arst_run", 0);
        expect_val("arst_score", 0);
        expect_val("arst_pass", 0);
        #3 rst4 = 1'b0;
        #1;
        check_next(X4);
        check_next(Y4);
        check_next(Q_Idle4);
        check_next(Q_Run4);
        check_next(Score4);
        check_next(Pass4);
        rst4 = 1'b1;

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
